// File: rtl/multi_cycle_controller_pkg.sv
// Shared encodings for the multi-cycle RV32I controller: FSM states,
// datapath select encodings, opcodes and the per-cycle control bundle.
package multi_cycle_controller_pkg;

   // FSM state encodings (debug-visible on cur_state)
   localparam logic [2:0] S_IF   = 3'd0;
   localparam logic [2:0] S_ID   = 3'd1;
   localparam logic [2:0] S_EX   = 3'd2;
   localparam logic [2:0] S_MEM  = 3'd3;
   localparam logic [2:0] S_WB   = 3'd4;
   localparam logic [2:0] S_BR   = 3'd5;
   localparam logic [2:0] S_HALT = 3'd6;

   // ALU operand B select
   localparam logic [1:0] SRCB_REG   = 2'b00;
   localparam logic [1:0] SRCB_FOUR  = 2'b01;
   localparam logic [1:0] SRCB_IMM   = 2'b10;

   // ALU operation class
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_BR    = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   // PC source
   localparam logic PCSRC_ALU    = 1'b0;
   localparam logic PCSRC_ALUOUT = 1'b1;

   // RV32I major opcodes the controller sequences
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   // One cycle's worth of datapath control
   typedef struct packed {
      logic       pc_write;
      logic       pc_source;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       reg_write;
      logic       wb_sel;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic       illegal_op;
   } ctrl_t;

   // Opcodes that continue to EX; ECALL is resolved in ID and not listed
   function automatic logic is_exec_op(input logic [6:0] op);
      return (op == OP_R) || (op == OP_I) || (op == OP_LOAD) || (op == OP_STORE) ||
             (op == OP_BRANCH) || (op == OP_JAL) || (op == OP_JALR);
   endfunction

endpackage

// File: rtl/multi_cycle_controller_if.sv
// Controller <-> datapath bundle. master = controller, slave = datapath.
// MC_MEM_READY_EN adds the mem_ready handshake from the memory.
interface multi_cycle_controller_if;
   logic [6:0] opcode;
   logic       bcond;
   logic       halt_req;
`ifdef MC_MEM_READY_EN
   logic       mem_ready;
`endif
   logic       pc_write;
   logic       pc_source;
   logic       i_or_d;
   logic       mem_read;
   logic       mem_write;
   logic       ir_write;
   logic       reg_write;
   logic       wb_sel;
   logic       alu_src_a;
   logic [1:0] alu_src_b;
   logic [1:0] alu_op;
   logic       illegal_op;
   logic       is_halted;
   logic [2:0] cur_state;

`ifdef MC_MEM_READY_EN
   modport master (input opcode, bcond, halt_req, mem_ready,
                   output pc_write, pc_source, i_or_d, mem_read, mem_write, ir_write,
                          reg_write, wb_sel, alu_src_a, alu_src_b, alu_op,
                          illegal_op, is_halted, cur_state);
   modport slave  (output opcode, bcond, halt_req, mem_ready,
                   input  pc_write, pc_source, i_or_d, mem_read, mem_write, ir_write,
                          reg_write, wb_sel, alu_src_a, alu_src_b, alu_op,
                          illegal_op, is_halted, cur_state);
`else
   modport master (input opcode, bcond, halt_req,
                   output pc_write, pc_source, i_or_d, mem_read, mem_write, ir_write,
                          reg_write, wb_sel, alu_src_a, alu_src_b, alu_op,
                          illegal_op, is_halted, cur_state);
   modport slave  (output opcode, bcond, halt_req,
                   input  pc_write, pc_source, i_or_d, mem_read, mem_write, ir_write,
                          reg_write, wb_sel, alu_src_a, alu_src_b, alu_op,
                          illegal_op, is_halted, cur_state);
`endif
endinterface

// File: rtl/multi_cycle_controller_wait_counter.sv
// Fixed-latency memory access counter: counts 0..MEM_LAT-1 while enabled,
// done on the last count, returns to 0 on done or clear.
module mc_wait_counter #(
   parameter int MEM_LAT = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic clr_i,
   input  logic en_i,
   output logic done_o
);
   localparam int W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

   logic [W-1:0] cnt_q, cnt_d;

   assign done_o = (cnt_q == W'(MEM_LAT - 1));

   // Next count: clear wins, wrap to 0 on the completing cycle
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i || done_o) cnt_d = '0;
      else if (en_i)       cnt_d = cnt_q + 1'b1;
   end

   // Count register
   always_ff @(posedge clk) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end
endmodule

// File: rtl/multi_cycle_controller.sv
// Multi-cycle RV32I sequencer (IF/ID/EX/MEM/WB/BR/HALT) driving a shared
// ALU and memory. MC_MEM_READY_EN: IF/MEM finish on mem_ready instead of
// the fixed MEM_LAT counter.
module multi_cycle_controller
   import multi_cycle_controller_pkg::*;
#(
   parameter int MEM_LAT = 1
) (
   input logic                      clk,
   input logic                      reset,
   multi_cycle_controller_if.master mc
);
   logic [2:0] state_q, state_d;
   ctrl_t      ctl, ctl_o;
   logic       access, done;

   assign access = (state_q == S_IF) || (state_q == S_MEM);

`ifdef MC_MEM_READY_EN
   assign done = mc.mem_ready;
`else
   logic cnt_clr;
   // Counter restarts whenever we are not in (or are leaving) an access state
   assign cnt_clr = !access || (state_d != state_q);

   mc_wait_counter #(.MEM_LAT(MEM_LAT)) u_wait (
      .clk    (clk),
      .reset  (reset),
      .clr_i  (cnt_clr),
      .en_i   (access),
      .done_o (done)
   );
`endif

   // Next state and per-state control
   always_comb begin
      state_d = state_q;
      ctl     = '0;
      case (state_q)
         S_IF: begin
            ctl.mem_read = 1'b1;
            ctl.ir_write = done;
            if (done) state_d = S_ID;
         end
         S_ID: begin
            ctl.alu_src_b = SRCB_FOUR;
            if (mc.opcode == OP_SYSTEM) begin
               if (mc.halt_req) state_d = S_HALT;
               else begin
                  ctl.pc_write = 1'b1;
                  state_d      = S_IF;
               end
            end else if (!is_exec_op(mc.opcode)) begin
               ctl.illegal_op = 1'b1;
               ctl.pc_write   = 1'b1;
               state_d        = S_IF;
            end else begin
               state_d = S_EX;
            end
         end
         S_EX: begin
            state_d = S_IF;
            case (mc.opcode)
               OP_R: begin
                  ctl.alu_src_a = 1'b1;
                  ctl.alu_op    = ALUOP_FUNCT;
                  state_d       = S_WB;
               end
               OP_I: begin
                  ctl.alu_src_a = 1'b1;
                  ctl.alu_src_b = SRCB_IMM;
                  ctl.alu_op    = ALUOP_FUNCT;
                  state_d       = S_WB;
               end
               OP_LOAD, OP_STORE: begin
                  ctl.alu_src_a = 1'b1;
                  ctl.alu_src_b = SRCB_IMM;
                  state_d       = S_MEM;
               end
               OP_BRANCH: begin
                  ctl.alu_src_a = 1'b1;
                  ctl.alu_op    = ALUOP_BR;
                  // Not taken: ALUOut already holds PC+4 from ID
                  if (!mc.bcond) begin
                     ctl.pc_write  = 1'b1;
                     ctl.pc_source = PCSRC_ALUOUT;
                  end else begin
                     state_d = S_BR;
                  end
               end
               OP_JAL, OP_JALR: begin
                  // Target from ALU this cycle; rd gets PC+4 still in ALUOut
                  ctl.alu_src_a = (mc.opcode == OP_JALR);
                  ctl.alu_src_b = SRCB_IMM;
                  ctl.pc_write  = 1'b1;
                  ctl.reg_write = 1'b1;
               end
               default: ;
            endcase
         end
         S_MEM: begin
            ctl.i_or_d = 1'b1;
            state_d    = S_IF;
            if (mc.opcode == OP_LOAD) begin
               ctl.mem_read = 1'b1;
               state_d      = done ? S_WB : S_MEM;
            end else if (mc.opcode == OP_STORE) begin
               ctl.mem_write = 1'b1;
               state_d       = S_MEM;
               // Last store cycle also advances PC by 4
               if (done) begin
                  ctl.alu_src_b = SRCB_FOUR;
                  ctl.pc_write  = 1'b1;
                  state_d       = S_IF;
               end
            end
         end
         S_WB: begin
            ctl.reg_write = 1'b1;
            ctl.wb_sel    = (mc.opcode == OP_LOAD);
            ctl.alu_src_b = SRCB_FOUR;
            ctl.pc_write  = 1'b1;
            state_d       = S_IF;
         end
         S_BR: begin
            ctl.alu_src_b = SRCB_IMM;
            ctl.pc_write  = 1'b1;
            state_d       = S_IF;
         end
         S_HALT: ;
         default: state_d = S_IF;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) state_q <= S_IF;
      else       state_q <= state_d;
   end

   // All outputs silenced while reset is asserted
   assign ctl_o = reset ? '0 : ctl;

   assign mc.pc_write   = ctl_o.pc_write;
   assign mc.pc_source  = ctl_o.pc_source;
   assign mc.i_or_d     = ctl_o.i_or_d;
   assign mc.mem_read   = ctl_o.mem_read;
   assign mc.mem_write  = ctl_o.mem_write;
   assign mc.ir_write   = ctl_o.ir_write;
   assign mc.reg_write  = ctl_o.reg_write;
   assign mc.wb_sel     = ctl_o.wb_sel;
   assign mc.alu_src_a  = ctl_o.alu_src_a;
   assign mc.alu_src_b  = ctl_o.alu_src_b;
   assign mc.alu_op     = ctl_o.alu_op;
   assign mc.illegal_op = ctl_o.illegal_op;
   assign mc.is_halted  = !reset && (state_q == S_HALT);
   assign mc.cur_state  = reset ? 3'd0 : state_q;
endmodule

// File: tb/tb_multi_cycle_controller.sv
// Directed bench for multi_cycle_controller: one instance with MEM_LAT=1,
// one with MEM_LAT=3, each with its own reset and interface.
`timescale 1ns/1ps
module tb_multi_cycle_controller;
   import multi_cycle_controller_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst1, rst3;
   multi_cycle_controller_if b1();
   multi_cycle_controller_if b3();

   multi_cycle_controller #(.MEM_LAT(1)) dut1 (.clk(clk), .reset(rst1), .mc(b1));
   multi_cycle_controller #(.MEM_LAT(3)) dut3 (.clk(clk), .reset(rst3), .mc(b3));

   int checks = 0;
   int errors = 0;

   // {state, pcw, pcs, iod, mr, mw, irw, rw, wb, a, b[1:0], op[1:0], ill, hlt}
   logic [17:0] o1, o3, exp;
   assign o1 = {b1.cur_state, b1.pc_write, b1.pc_source, b1.i_or_d, b1.mem_read, b1.mem_write,
                b1.ir_write, b1.reg_write, b1.wb_sel, b1.alu_src_a, b1.alu_src_b, b1.alu_op,
                b1.illegal_op, b1.is_halted};
   assign o3 = {b3.cur_state, b3.pc_write, b3.pc_source, b3.i_or_d, b3.mem_read, b3.mem_write,
                b3.ir_write, b3.reg_write, b3.wb_sel, b3.alu_src_a, b3.alu_src_b, b3.alu_op,
                b3.illegal_op, b3.is_halted};

   function automatic logic [17:0] ev(input logic [2:0] st, input logic pcw, pcs, iod, mr, mw,
                                      irw, rw, wb, a, input logic [1:0] b, op, input logic ill, hlt);
      return {st, pcw, pcs, iod, mr, mw, irw, rw, wb, a, b, op, ill, hlt};
   endfunction

   logic [17:0] V_IFD, V_IFW, V_ID, V_IDPC, V_ILL, V_EXR, V_EXI, V_EXLS, V_EXBNT, V_EXBT,
                V_BR, V_JAL, V_JALR, V_WBR, V_WBL, V_MEMSW, V_MEMSWW, V_MEMLW, V_HALT;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst1 = 1'b1; rst3 = 1'b1;
      b1.opcode = OP_R; b1.bcond = 1'b0; b1.halt_req = 1'b0;
      b3.opcode = OP_LOAD; b3.bcond = 1'b0; b3.halt_req = 1'b0;
      #1;
      exp = '0; checks++; if (o1 !== exp) begin errors++; $display("FAIL reset_async_outs got=%h exp=%h", o1, exp); end
      tick(); tick();
      exp = '0; checks++; if (o1 !== exp) begin errors++; $display("FAIL reset_outs1 got=%h exp=%h", o1, exp); end
      exp = '0; checks++; if (o3 !== exp) begin errors++; $display("FAIL reset_outs3 got=%h exp=%h", o3, exp); end
      rst1 = 1'b0; #1;
      exp = V_IFD; checks++; if (o1 !== exp) begin errors++; $display("FAIL reset_to_if got=%h exp=%h", o1, exp); end
   endtask

   task automatic test_add();
      b1.opcode = OP_R;
      tick(); exp = V_ID;  checks++; if (o1 !== exp) begin errors++; $display("FAIL add_id got=%h exp=%h", o1, exp); end
      tick(); exp = V_EXR; checks++; if (o1 !== exp) begin errors++; $display("FAIL add_ex got=%h exp=%h", o1, exp); end
      tick(); exp = V_WBR; checks++; if (o1 !== exp) begin errors++; $display("FAIL add_wb got=%h exp=%h", o1, exp); end
      tick(); exp = V_IFD; checks++; if (o1 !== exp) begin errors++; $display("FAIL add_next_if got=%h exp=%h", o1, exp); end
   endtask

   task automatic test_addi();
      b1.opcode = OP_I;
      tick(); exp = V_ID;  checks++; if (o1 !== exp) begin errors++; $display("FAIL addi_id got=%h exp=%h", o1, exp); end
      tick(); exp = V_EXI; checks++; if (o1 !== exp) begin errors++; $display("FAIL addi_ex got=%h exp=%h", o1, exp); end
      tick(); exp = V_WBR; checks++; if (o1 !== exp) begin errors++; $display("FAIL addi_wb got=%h exp=%h", o1, exp); end
      tick(); exp = V_IFD; checks++; if (o1 !== exp) begin errors++; $display("FAIL addi_next_if got=%h exp=%h", o1, exp); end
   endtask

   task automatic test_branch();
      b1.opcode = OP_BRANCH; b1.bcond = 1'b0;
      tick(); exp = V_ID;    checks++; if (o1 !== exp) begin errors++; $display("FAIL bnt_id got=%h exp=%h", o1, exp); end
      tick(); exp = V_EXBNT; checks++; if (o1 !== exp) begin errors++; $display("FAIL bnt_ex got=%h exp=%h", o1, exp); end
      tick(); exp = V_IFD;   checks++; if (o1 !== exp) begin errors++; $display("FAIL bnt_next_if got=%h exp=%h", o1, exp); end
      b1.bcond = 1'b1;
      tick(); exp = V_ID;    checks++; if (o1 !== exp) begin errors++; $display("FAIL bt_id got=%h exp=%h", o1, exp); end
      tick(); exp = V_EXBT;  checks++; if (o1 !== exp) begin errors++; $display("FAIL bt_ex got=%h exp=%h", o1, exp); end
      tick(); exp = V_BR;    checks++; if (o1 !== exp) begin errors++; $display("FAIL bt_br got=%h exp=%h", o1, exp); end
      tick(); exp = V_IFD;   checks++; if (o1 !== exp) begin errors++; $display("FAIL bt_next_if got=%h exp=%h", o1, exp); end
      b1.bcond = 1'b0;
   endtask

   task automatic test_jump();
      b1.opcode = OP_JAL;
      tick(); exp = V_ID;   checks++; if (o1 !== exp) begin errors++; $display("FAIL jal_id got=%h exp=%h", o1, exp); end
      tick(); exp = V_JAL;  checks++; if (o1 !== exp) begin errors++; $display("FAIL jal_ex got=%h exp=%h", o1, exp); end
      tick(); exp = V_IFD;  checks++; if (o1 !== exp) begin errors++; $display("FAIL jal_next_if got=%h exp=%h", o1, exp); end
      b1.opcode = OP_JALR;
      tick(); exp = V_ID;   checks++; if (o1 !== exp) begin errors++; $display("FAIL jalr_id got=%h exp=%h", o1, exp); end
      tick(); exp = V_JALR; checks++; if (o1 !== exp) begin errors++; $display("FAIL jalr_ex got=%h exp=%h", o1, exp); end
      tick(); exp = V_IFD;  checks++; if (o1 !== exp) begin errors++; $display("FAIL jalr_next_if got=%h exp=%h", o1, exp); end
   endtask

   task automatic test_store();
      b1.opcode = OP_STORE;
      tick(); exp = V_ID;    checks++; if (o1 !== exp) begin errors++; $display("FAIL sw_id got=%h exp=%h", o1, exp); end
      tick(); exp = V_EXLS;  checks++; if (o1 !== exp) begin errors++; $display("FAIL sw_ex got=%h exp=%h", o1, exp); end
      tick(); exp = V_MEMSW; checks++; if (o1 !== exp) begin errors++; $display("FAIL sw_mem got=%h exp=%h", o1, exp); end
      tick(); exp = V_IFD;   checks++; if (o1 !== exp) begin errors++; $display("FAIL sw_next_if got=%h exp=%h", o1, exp); end
   endtask

   task automatic test_illegal();
      b1.opcode = 7'b0110111;
      tick(); exp = V_ILL; checks++; if (o1 !== exp) begin errors++; $display("FAIL illegal_id got=%h exp=%h", o1, exp); end
      tick(); exp = V_IFD; checks++; if (o1 !== exp) begin errors++; $display("FAIL illegal_next_if got=%h exp=%h", o1, exp); end
   endtask

   task automatic test_ecall();
      b1.opcode = OP_SYSTEM; b1.halt_req = 1'b0;
      tick(); exp = V_IDPC; checks++; if (o1 !== exp) begin errors++; $display("FAIL ecall_nohalt_id got=%h exp=%h", o1, exp); end
      tick(); exp = V_IFD;  checks++; if (o1 !== exp) begin errors++; $display("FAIL ecall_nohalt_if got=%h exp=%h", o1, exp); end
      b1.halt_req = 1'b1;
      tick(); exp = V_ID;   checks++; if (o1 !== exp) begin errors++; $display("FAIL ecall_halt_id got=%h exp=%h", o1, exp); end
      tick();
      b1.halt_req = 1'b0; b1.opcode = OP_R;
      for (int i = 0; i < 11; i++) begin
         exp = V_HALT; checks++; if (o1 !== exp) begin errors++; $display("FAIL halt_hold_%0d got=%h exp=%h", i, o1, exp); end
         tick();
      end
      rst1 = 1'b1; #1;
      exp = '0; checks++; if (o1 !== exp) begin errors++; $display("FAIL halt_reset_outs got=%h exp=%h", o1, exp); end
      tick();
      rst1 = 1'b0; #1;
      exp = V_IFD; checks++; if (o1 !== exp) begin errors++; $display("FAIL halt_reset_if got=%h exp=%h", o1, exp); end
   endtask

   task automatic test_lw_lat3();
      b3.opcode = OP_LOAD;
      rst3 = 1'b0; #1;
      exp = V_IFW;  checks++; if (o3 !== exp) begin errors++; $display("FAIL lw3_if0 got=%h exp=%h", o3, exp); end
      tick(); exp = V_IFW;  checks++; if (o3 !== exp) begin errors++; $display("FAIL lw3_if1 got=%h exp=%h", o3, exp); end
      tick(); exp = V_IFD;  checks++; if (o3 !== exp) begin errors++; $display("FAIL lw3_if2 got=%h exp=%h", o3, exp); end
      tick(); exp = V_ID;   checks++; if (o3 !== exp) begin errors++; $display("FAIL lw3_id got=%h exp=%h", o3, exp); end
      tick(); exp = V_EXLS; checks++; if (o3 !== exp) begin errors++; $display("FAIL lw3_ex got=%h exp=%h", o3, exp); end
      for (int i = 0; i < 3; i++) begin
         tick(); exp = V_MEMLW; checks++; if (o3 !== exp) begin errors++; $display("FAIL lw3_mem%0d got=%h exp=%h", i, o3, exp); end
      end
      tick(); exp = V_WBL; checks++; if (o3 !== exp) begin errors++; $display("FAIL lw3_wb got=%h exp=%h", o3, exp); end
      tick(); exp = V_IFW; checks++; if (o3 !== exp) begin errors++; $display("FAIL lw3_next_if got=%h exp=%h", o3, exp); end
   endtask

   task automatic test_reset_mid_store();
      b3.opcode = OP_STORE;
      tick(); exp = V_IFW;    checks++; if (o3 !== exp) begin errors++; $display("FAIL rsw_if1 got=%h exp=%h", o3, exp); end
      tick(); exp = V_IFD;    checks++; if (o3 !== exp) begin errors++; $display("FAIL rsw_if2 got=%h exp=%h", o3, exp); end
      tick(); exp = V_ID;     checks++; if (o3 !== exp) begin errors++; $display("FAIL rsw_id got=%h exp=%h", o3, exp); end
      tick(); exp = V_EXLS;   checks++; if (o3 !== exp) begin errors++; $display("FAIL rsw_ex got=%h exp=%h", o3, exp); end
      tick(); exp = V_MEMSWW; checks++; if (o3 !== exp) begin errors++; $display("FAIL rsw_mem0 got=%h exp=%h", o3, exp); end
      tick(); exp = V_MEMSWW; checks++; if (o3 !== exp) begin errors++; $display("FAIL rsw_mem1 got=%h exp=%h", o3, exp); end
      rst3 = 1'b1; #1;
      checks++; if (b3.mem_write !== 1'b0) begin errors++; $display("FAIL rsw_memwrite_in_reset got=%b exp=0", b3.mem_write); end
      exp = '0; checks++; if (o3 !== exp) begin errors++; $display("FAIL rsw_outs_in_reset got=%h exp=%h", o3, exp); end
      tick();
      rst3 = 1'b0; #1;
      exp = V_IFW; checks++; if (o3 !== exp) begin errors++; $display("FAIL rsw_after_if0 got=%h exp=%h", o3, exp); end
      tick(); exp = V_IFW; checks++; if (o3 !== exp) begin errors++; $display("FAIL rsw_after_if1 got=%h exp=%h", o3, exp); end
      tick(); exp = V_IFD; checks++; if (o3 !== exp) begin errors++; $display("FAIL rsw_after_if2 got=%h exp=%h", o3, exp); end
      tick(); exp = V_ID;  checks++; if (o3 !== exp) begin errors++; $display("FAIL rsw_after_id got=%h exp=%h", o3, exp); end
   endtask

   initial begin
      //            st  pcw pcs iod mr mw irw rw wb a  b      op     ill hlt
      V_IFD    = ev(0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0);
      V_IFW    = ev(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
      V_ID     = ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 0, 0);
      V_IDPC   = ev(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 0, 0);
      V_ILL    = ev(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 1, 0);
      V_EXR    = ev(2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b10, 0, 0);
      V_EXI    = ev(2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b10, 0, 0);
      V_EXLS   = ev(2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 0, 0);
      V_EXBNT  = ev(2, 1, 1, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 0, 0);
      V_EXBT   = ev(2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 0, 0);
      V_BR     = ev(5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 0, 0);
      V_JAL    = ev(2, 1, 0, 0, 0, 0, 0, 1, 0, 0, 2'b10, 2'b00, 0, 0);
      V_JALR   = ev(2, 1, 0, 0, 0, 0, 0, 1, 0, 1, 2'b10, 2'b00, 0, 0);
      V_WBR    = ev(4, 1, 0, 0, 0, 0, 0, 1, 0, 0, 2'b01, 2'b00, 0, 0);
      V_WBL    = ev(4, 1, 0, 0, 0, 0, 0, 1, 1, 0, 2'b01, 2'b00, 0, 0);
      V_MEMSW  = ev(3, 1, 0, 1, 0, 1, 0, 0, 0, 0, 2'b01, 2'b00, 0, 0);
      V_MEMSWW = ev(3, 0, 0, 1, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
      V_MEMLW  = ev(3, 0, 0, 1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
      V_HALT   = ev(6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1);

      test_reset();
      test_add();
      test_addi();
      test_branch();
      test_jump();
      test_store();
      test_illegal();
      test_ecall();
      test_lw_lat3();
      test_reset_mid_store();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog time limit reached checks=%0d errors=%0d", checks, errors);
      $fatal(1);
   end
endmodule
